// File: rtl/monitor_pkg.sv
// monitor_pkg: shared types and constants for test_status_monitor.
//   state_e             - 3-bit monitor state encoding
//   DEFAULT_STATUS_ADDR - CSR address used to report test status
//   DEFAULT_PASS_CODE / DEFAULT_FAIL_CODE - status values that end a test
//   popcount4()         - number of set bits in a 4-bit lane mask
package monitor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_e;

  localparam logic [11:0] DEFAULT_STATUS_ADDR = 12'h7C0;
  localparam logic [31:0] DEFAULT_PASS_CODE   = 32'h0000_0001;
  localparam logic [31:0] DEFAULT_FAIL_CODE   = 32'h0000_DEAD;

  localparam int unsigned MAX_LANES = 4;
  localparam int unsigned LANE_CNT_W = 3;

  function automatic logic [LANE_CNT_W-1:0] popcount4(input logic [MAX_LANES-1:0] v);
    logic [LANE_CNT_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      c = c + {{(LANE_CNT_W-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter.
//   clk_i, reset_n_i - clock, asynchronous active-low reset
//   clear_i          - synchronous zero, wins over en_i
//   en_i             - add inc_i this edge
//   inc_i            - increment amount (INC_WIDTH bits, INC_WIDTH <= WIDTH)
//   cnt_o            - current count; sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned INC_WIDTH = 1
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 clear_i,
  input  logic                 en_i,
  input  logic [INC_WIDTH-1:0] inc_i,
  output logic [WIDTH-1:0]     cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH:0]   inc_ext;
  logic [WIDTH:0]   sum;

  always_comb begin
    inc_ext                 = '0;
    inc_ext[INC_WIDTH-1:0]  = inc_i;
    // One extra bit catches the carry out that means "would wrap".
    sum                     = {1'b0, cnt_q} + inc_ext;
    cnt_d                   = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/test_status_monitor.sv
// test_status_monitor: watches writeback retirement and a status CSR to
// decide whether a test passed, failed or timed out.
//   clk_i, reset_n_i         - clock, asynchronous active-low reset
//   clear_i                  - synchronous restart to IDLE, counters zeroed
//   valid_w_i [NUM_LANES]    - per-lane retire valid
//   stall_w_i                - writeback stall, qualifies retire and CSR write
//   csr_we_w_i/addr/wdata    - writeback CSR write
//   state_o                  - monitor state (monitor_pkg::state_e)
//   done_o/pass_o/fail_o/timeout_o - registered terminal-state flags
//   cycle_cnt_o/instret_cnt_o/stall_cnt_o - saturating counters
//   last_code_o              - last value written to the status CSR
// Build option: define MONITOR_STALL_CNT_EN to include the stall counter;
// otherwise stall_cnt_o is constant zero.
module test_status_monitor
  import monitor_pkg::*;
#(
  parameter int unsigned NUM_LANES      = 1,
  parameter int unsigned CNT_WIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [11:0] STATUS_ADDR    = DEFAULT_STATUS_ADDR,
  parameter logic [31:0] PASS_CODE      = DEFAULT_PASS_CODE,
  parameter logic [31:0] FAIL_CODE      = DEFAULT_FAIL_CODE
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 clear_i,
  input  logic [NUM_LANES-1:0] valid_w_i,
  input  logic                 stall_w_i,
  input  logic                 csr_we_w_i,
  input  logic [11:0]          csr_addr_w_i,
  input  logic [31:0]          csr_wdata_w_i,
  output logic [2:0]           state_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic                 fail_o,
  output logic                 timeout_o,
  output logic [CNT_WIDTH-1:0] cycle_cnt_o,
  output logic [CNT_WIDTH-1:0] instret_cnt_o,
  output logic [CNT_WIDTH-1:0] stall_cnt_o,
  output logic [31:0]          last_code_o
);

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_e                state_q, state_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic                  fail_q, fail_d;
  logic                  timeout_q, timeout_d;
  logic [31:0]           last_code_q, last_code_d;

  logic                  active;
  logic                  retire;
  logic                  status_wr;
  logic                  timeout_hit;
  logic [MAX_LANES-1:0]  valid_pad;
  logic [LANE_CNT_W-1:0] retire_cnt;
  logic [CNT_WIDTH-1:0]  cycle_cnt;

  always_comb begin
    valid_pad                = '0;
    valid_pad[NUM_LANES-1:0] = valid_w_i;
    retire_cnt               = popcount4(valid_pad);
    active                   = (state_q == ST_IDLE) || (state_q == ST_RUN);
    retire                   = (valid_w_i != '0) && !stall_w_i;
    status_wr                = csr_we_w_i && !stall_w_i && (csr_addr_w_i == STATUS_ADDR);
    timeout_hit              = (cycle_cnt == TIMEOUT_LAST);
  end

  // State register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: clear beats everything, a status write beats the watchdog.
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = ST_IDLE;
    end else if (active) begin
      if (status_wr && (csr_wdata_w_i == PASS_CODE)) begin
        state_d = ST_PASS;
      end else if (status_wr && (csr_wdata_w_i == FAIL_CODE)) begin
        state_d = ST_FAIL;
      end else if (timeout_hit) begin
        state_d = ST_TIMEOUT;
      end else if ((state_q == ST_IDLE) && retire) begin
        state_d = ST_RUN;
      end
    end
  end

  // Outputs: flags decoded from the next state so they are flops aligned
  // with state_q rather than combinational decodes of it.
  always_comb begin
    done_d      = (state_d == ST_PASS) || (state_d == ST_FAIL) || (state_d == ST_TIMEOUT);
    pass_d      = (state_d == ST_PASS);
    fail_d      = (state_d == ST_FAIL);
    timeout_d   = (state_d == ST_TIMEOUT);
    last_code_d = last_code_q;
    if (clear_i) begin
      last_code_d = '0;
    end else if (active && status_wr) begin
      last_code_d = csr_wdata_w_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
      last_code_q <= '0;
    end else begin
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      timeout_q   <= timeout_d;
      last_code_q <= last_code_d;
    end
  end

  sat_counter #(
    .WIDTH     (CNT_WIDTH),
    .INC_WIDTH (1)
  ) u_cycle_cnt (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (clear_i),
    .en_i      (active),
    .inc_i     (1'b1),
    .cnt_o     (cycle_cnt)
  );

  sat_counter #(
    .WIDTH     (CNT_WIDTH),
    .INC_WIDTH (LANE_CNT_W)
  ) u_instret_cnt (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (clear_i),
    .en_i      (active && !stall_w_i),
    .inc_i     (retire_cnt),
    .cnt_o     (instret_cnt_o)
  );

`ifdef MONITOR_STALL_CNT_EN
  sat_counter #(
    .WIDTH     (CNT_WIDTH),
    .INC_WIDTH (1)
  ) u_stall_cnt (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (clear_i),
    .en_i      ((state_q == ST_RUN) && stall_w_i),
    .inc_i     (1'b1),
    .cnt_o     (stall_cnt_o)
  );
`else
  assign stall_cnt_o = '0;
`endif

  assign state_o     = state_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign fail_o      = fail_q;
  assign timeout_o   = timeout_q;
  assign cycle_cnt_o = cycle_cnt;
  assign last_code_o = last_code_q;

endmodule

// File: tb/tb_test_status_monitor.sv
// Bench for test_status_monitor (NUM_LANES=2, TIMEOUT_CYCLES=16) plus a
// stand-alone 32-bit sat_counter for the saturation boundary.
module tb_test_status_monitor;

  logic        clk;
  logic        reset_n;
  logic        clear;
  logic [1:0]  valid;
  logic        stall;
  logic        we;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic [2:0]  state;
  logic        done, pass, fail, tmo;
  logic [31:0] cyc, inst, stl, code;

  logic        sat_clr, sat_en;
  logic [31:0] sat_inc, sat_cnt;

  int n_cmp = 0;
  int n_err = 0;

`ifdef MONITOR_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  test_status_monitor #(
    .NUM_LANES      (2),
    .CNT_WIDTH      (32),
    .TIMEOUT_CYCLES (16),
    .STATUS_ADDR    (12'h7C0),
    .PASS_CODE      (32'h1),
    .FAIL_CODE      (32'h0DEAD)
  ) dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n),
    .clear_i       (clear),
    .valid_w_i     (valid),
    .stall_w_i     (stall),
    .csr_we_w_i    (we),
    .csr_addr_w_i  (addr),
    .csr_wdata_w_i (wdata),
    .state_o       (state),
    .done_o        (done),
    .pass_o        (pass),
    .fail_o        (fail),
    .timeout_o     (tmo),
    .cycle_cnt_o   (cyc),
    .instret_cnt_o (inst),
    .stall_cnt_o   (stl),
    .last_code_o   (code)
  );

  sat_counter #(
    .WIDTH     (32),
    .INC_WIDTH (32)
  ) u_sat (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .clear_i   (sat_clr),
    .en_i      (sat_en),
    .inc_i     (sat_inc),
    .cnt_o     (sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        clr;
    logic [1:0]  valid;
    logic        stall;
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [2:0]  st;
    logic [31:0] cyc;
    logic [31:0] inst;
    logic [31:0] stl;
    logic [31:0] code;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic clr, input logic [1:0] v, input logic s,
                              input logic w, input logic [11:0] a, input logic [31:0] d,
                              input logic [2:0] st, input int c, input int i,
                              input int sc, input logic [31:0] cd);
    vec_t r;
    r.clr = clr; r.valid = v; r.stall = s; r.we = w; r.addr = a; r.wdata = d;
    r.st = st; r.cyc = c; r.inst = i; r.stl = sc; r.code = cd;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] st, input logic [31:0] c,
                           input logic [31:0] i, input logic [31:0] sc, input logic [31:0] cd);
    logic [3:0] exp_flags;
    exp_flags = {(st == 3'd2) || (st == 3'd3) || (st == 3'd4),
                 st == 3'd2, st == 3'd3, st == 3'd4};
    chk({tag, ".state"},   {29'd0, state}, {29'd0, st});
    chk({tag, ".flags"},   {28'd0, done, pass, fail, tmo}, {28'd0, exp_flags});
    chk({tag, ".cycle"},   cyc, c);
    chk({tag, ".instret"}, inst, i);
    chk({tag, ".stall"},   stl, STALL_EN ? sc : 32'd0);
    chk({tag, ".code"},    code, cd);
  endtask

  task automatic drive(input logic c, input logic [1:0] v, input logic s,
                       input logic w, input logic [11:0] a, input logic [31:0] d);
    clear = c; valid = v; stall = s; we = w; addr = a; wdata = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // States: 0 IDLE, 1 RUN, 2 PASS, 3 FAIL, 4 TIMEOUT
    // Retire and stall accounting, status write qualification, PASS freeze, clear priority
    vecs.push_back(mk(1, 2'b00, 0, 0, 12'h000, 32'h0,     0,  0,  0, 0, 32'h0));
    vecs.push_back(mk(0, 2'b00, 0, 0, 12'h000, 32'h0,     0,  1,  0, 0, 32'h0));
    vecs.push_back(mk(0, 2'b11, 1, 0, 12'h000, 32'h0,     0,  2,  0, 0, 32'h0));
    vecs.push_back(mk(0, 2'b11, 0, 0, 12'h000, 32'h0,     1,  3,  2, 0, 32'h0));
    vecs.push_back(mk(0, 2'b11, 0, 0, 12'h000, 32'h0,     1,  4,  4, 0, 32'h0));
    vecs.push_back(mk(0, 2'b11, 0, 0, 12'h000, 32'h0,     1,  5,  6, 0, 32'h0));
    vecs.push_back(mk(0, 2'b11, 0, 0, 12'h000, 32'h0,     1,  6,  8, 0, 32'h0));
    vecs.push_back(mk(0, 2'b11, 0, 0, 12'h000, 32'h0,     1,  7, 10, 0, 32'h0));
    vecs.push_back(mk(0, 2'b01, 1, 0, 12'h000, 32'h0,     1,  8, 10, 1, 32'h0));
    vecs.push_back(mk(0, 2'b10, 0, 0, 12'h000, 32'h0,     1,  9, 11, 1, 32'h0));
    vecs.push_back(mk(0, 2'b00, 0, 1, 12'h7C0, 32'h1234,  1, 10, 11, 1, 32'h1234));
    vecs.push_back(mk(0, 2'b00, 0, 1, 12'h7C1, 32'h1,     1, 11, 11, 1, 32'h1234));
    vecs.push_back(mk(0, 2'b00, 1, 1, 12'h7C0, 32'h1,     1, 12, 11, 2, 32'h1234));
    vecs.push_back(mk(0, 2'b00, 0, 1, 12'h7C0, 32'h1,     2, 13, 11, 2, 32'h1));
    vecs.push_back(mk(0, 2'b11, 1, 1, 12'h7C0, 32'hDEAD,  2, 13, 11, 2, 32'h1));
    vecs.push_back(mk(0, 2'b11, 0, 0, 12'h000, 32'h0,     2, 13, 11, 2, 32'h1));
    vecs.push_back(mk(1, 2'b11, 0, 1, 12'h7C0, 32'hDEAD,  0,  0,  0, 0, 32'h0));
    // Watchdog: TIMEOUT on the edge where cycle_cnt is 15
    vecs.push_back(mk(0, 2'b01, 0, 0, 12'h000, 32'h0,     1,  1,  1, 0, 32'h0));
    for (int k = 2; k <= 15; k++)
      vecs.push_back(mk(0, 2'b00, 0, 0, 12'h000, 32'h0,   1,  k,  1, 0, 32'h0));
    vecs.push_back(mk(0, 2'b00, 0, 0, 12'h000, 32'h0,     4, 16,  1, 0, 32'h0));
    vecs.push_back(mk(0, 2'b11, 0, 0, 12'h000, 32'h0,     4, 16,  1, 0, 32'h0));
    vecs.push_back(mk(1, 2'b00, 0, 0, 12'h000, 32'h0,     0,  0,  0, 0, 32'h0));
    // FAIL write on the timeout edge wins; stalled RUN cycles counted
    vecs.push_back(mk(0, 2'b10, 0, 0, 12'h000, 32'h0,     1,  1,  1, 0, 32'h0));
    for (int k = 2; k <= 15; k++)
      vecs.push_back(mk(0, 2'b00, 1, 0, 12'h000, 32'h0,   1,  k,  1, k - 1, 32'h0));
    vecs.push_back(mk(0, 2'b00, 0, 1, 12'h7C0, 32'hDEAD,  3, 16,  1, 14, 32'hDEAD));
    vecs.push_back(mk(0, 2'b00, 0, 0, 12'h000, 32'h0,     3, 16,  1, 14, 32'hDEAD));
    // Non-terminal code in IDLE, then PASS write wins over first retire
    vecs.push_back(mk(1, 2'b00, 0, 0, 12'h000, 32'h0,     0,  0,  0, 0, 32'h0));
    vecs.push_back(mk(0, 2'b00, 0, 1, 12'h7C0, 32'h55,    0,  1,  0, 0, 32'h55));
    vecs.push_back(mk(0, 2'b11, 0, 1, 12'h7C0, 32'h1,     2,  2,  2, 0, 32'h1));

    drive(0, 2'b00, 0, 0, 12'h000, 32'h0);
    sat_clr = 1'b0; sat_en = 1'b0; sat_inc = '0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    @(posedge clk); #2;
    check_all("reset", 3'd0, 0, 0, 0, 32'h0);
    chk("reset.sat", sat_cnt, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[n]) begin
      drive(vecs[n].clr, vecs[n].valid, vecs[n].stall, vecs[n].we, vecs[n].addr, vecs[n].wdata);
      tick();
      check_all($sformatf("v%0d", n), vecs[n].st, vecs[n].cyc, vecs[n].inst, vecs[n].stl, vecs[n].code);
    end

    // Asynchronous reset in the middle of RUN
    drive(1, 2'b00, 0, 0, 12'h000, 32'h0);
    tick();
    drive(0, 2'b11, 0, 0, 12'h000, 32'h0);
    tick(); tick(); tick();
    check_all("mr.run", 3'd1, 3, 6, 0, 32'h0);
    #2 reset_n = 1'b0;
    #1 check_all("mr.async", 3'd0, 0, 0, 0, 32'h0);
    drive(0, 2'b00, 0, 0, 12'h000, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    #1 check_all("mr.release", 3'd0, 0, 0, 0, 32'h0);
    tick();
    check_all("mr.first", 3'd0, 1, 0, 0, 32'h0);

    // 32-bit saturation boundary on a stand-alone counter
    sat_clr = 1'b1; sat_en = 1'b0; sat_inc = 32'h0;
    tick(); chk("sat.clr0", sat_cnt, 32'h0);
    sat_clr = 1'b0; sat_en = 1'b1; sat_inc = 32'h7FFF_FFFF;
    tick(); chk("sat.half", sat_cnt, 32'h7FFF_FFFF);
    sat_inc = 32'h8000_0000;
    tick(); chk("sat.exact", sat_cnt, 32'hFFFF_FFFF);
    sat_inc = 32'h1;
    tick(); chk("sat.over", sat_cnt, 32'hFFFF_FFFF);
    sat_inc = 32'h8000_0000;
    tick(); chk("sat.over2", sat_cnt, 32'hFFFF_FFFF);
    sat_en = 1'b0; sat_inc = 32'h5;
    tick(); chk("sat.hold", sat_cnt, 32'hFFFF_FFFF);
    sat_clr = 1'b1; sat_en = 1'b1;
    tick(); chk("sat.clr", sat_cnt, 32'h0);
    sat_clr = 1'b0;
    tick(); chk("sat.after", sat_cnt, 32'h5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
